// File: rtl/pwm_multi_gen_pkg.sv
// Shared definitions for the multi-channel PWM generator.
// Holds the saturation helper, counter direction codes and the channel-index
// width macro used to size the direct-write channel select.

`ifndef PWM_MULTI_GEN_PKG_SV
`define PWM_MULTI_GEN_PKG_SV

// Channel-select width; never narrower than one bit so a single-channel
// build still has a legal port.
`define PWM_CH_W(n) (((n) > 1) ? $clog2(n) : 1)

package pwm_multi_gen_pkg;

  // Up/down counter direction codes (centre-aligned build only).
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Clamp v into [lo, hi].
  function automatic int unsigned sat_clamp(input int unsigned v,
                                            input int unsigned lo,
                                            input int unsigned hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

`endif

// File: rtl/pwm_multi_gen_btn_edge.sv
// Tick-sampled button edge detector: one event per press, held level ignored.
// Sampling only on the shared slow tick gives the debounce.

module pwm_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic evt
);

  logic s1, s2;

  // Two-deep sample history, advanced once per debounce tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (tick) begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Rising edge between the last two samples, reported on the next tick.
  assign evt = s1 & ~s2 & tick;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with one shared period counter.
// Each channel's duty is nudged by debounced inc/dec buttons or written
// directly; changes land in duty_next and are copied to duty_act only when
// the counter wraps to 0, so an output never changes duty mid-period.
// Build option: define PWM_CENTER_ALIGN_EN for an up/down (centre-aligned)
// counter; otherwise the counter is edge-aligned.

module pwm_multi_gen
  import pwm_multi_gen_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 10,
  parameter int DUTY_INIT = 5,
  parameter int DUTY_MIN  = 1,
  parameter int DUTY_MAX  = 9,
  parameter int DEB_DIV   = 25000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             increase_duty,
  input  logic [NUM_CH-1:0]             decrease_duty,
  input  logic                          duty_wr_en,
  input  logic [`PWM_CH_W(NUM_CH)-1:0]  duty_wr_ch,
  input  logic [CNT_W-1:0]              duty_wr_data,
  output logic [NUM_CH-1:0]             PWM_OUT,
  output logic [NUM_CH*CNT_W-1:0]       duty_o,
  output logic                          period_start
);

  localparam int CH_W  = `PWM_CH_W(NUM_CH);
  localparam int DEB_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] D_MIN   = CNT_W'(DUTY_MIN);
  localparam logic [CNT_W-1:0] D_MAX   = CNT_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0] D_INIT  = CNT_W'(DUTY_INIT);

  logic [DEB_W-1:0]             deb_cnt;
  logic                         tick;
  logic [NUM_CH-1:0]            inc_evt, dec_evt;
  logic [CNT_W-1:0]             cnt;
  logic                         wrap;
  logic [CNT_W-1:0]             wr_cl;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_next, duty_act;

  // Debounce tick divider: free-running 0..DEB_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    deb_cnt <= '0;
    else if (tick) deb_cnt <= '0;
    else           deb_cnt <= deb_cnt + 1'b1;
  end

  assign tick = (deb_cnt == DEB_W'(DEB_DIV - 1));

  pwm_btn_edge u_inc [NUM_CH-1:0] (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn   (increase_duty),
    .evt   (inc_evt)
  );

  pwm_btn_edge u_dec [NUM_CH-1:0] (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn   (decrease_duty),
    .evt   (dec_evt)
  );

`ifdef PWM_CENTER_ALIGN_EN
  logic dir;

  // Up 0..PERIOD-1, then down PERIOD-2..1; PERIOD=2 degenerates to 0,1,0,1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (dir == DIR_UP) begin
      if (cnt == CNT_TOP) begin
        if (PERIOD == 2) begin
          cnt <= '0;
        end else begin
          cnt <= CNT_TOP - 1'b1;
          dir <= DIR_DOWN;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) dir <= DIR_UP;
    end
  end

  // The next count is 0 only at the end of the down slope (or the PERIOD=2 case).
  assign wrap = (dir == DIR_UP) ? ((PERIOD == 2) && (cnt == CNT_TOP))
                                : (cnt == CNT_W'(1));
`else
  // Edge-aligned period counter 0..PERIOD-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               cnt <= '0;
    else if (cnt == CNT_TOP)  cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign wrap = (cnt == CNT_TOP);
`endif

  assign wr_cl = CNT_W'(sat_clamp(32'(duty_wr_data), DUTY_MIN, DUTY_MAX));

  // Pending duty: direct write wins and swallows same-cycle button events;
  // simultaneous inc+dec cancel; inc/dec saturate at the bounds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_next <= {NUM_CH{D_INIT}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (duty_wr_en && (duty_wr_ch == CH_W'(i))) begin
          duty_next[i] <= wr_cl;
        end else if (inc_evt[i] && !dec_evt[i]) begin
          if (duty_next[i] < D_MAX) duty_next[i] <= duty_next[i] + 1'b1;
        end else if (dec_evt[i] && !inc_evt[i]) begin
          if (duty_next[i] > D_MIN) duty_next[i] <= duty_next[i] - 1'b1;
        end
      end
    end
  end

  // Shadow load on the clock the counter returns to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    duty_act <= {NUM_CH{D_INIT}};
    else if (wrap) duty_act <= duty_next;
  end

  // Registered compare outputs; period_start lines up with PWM_OUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PWM_OUT      <= '0;
      period_start <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) PWM_OUT[i] <= (cnt < duty_act[i]);
      period_start <= (cnt == '0);
    end
  end

  assign duty_o = duty_act;

endmodule
